// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto a single-port synchronous memory
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int MEM_AW       = 10,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_DREAD,
      OWN_DWRITE
   } owner_e;

   owner_e        owner_q, owner_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          streak_full;
   logic          fetch_ok;

   // Only the word-address slice of each byte address reaches memory.
   logic unused_addr;
   assign unused_addr = ^{if_addr, d_addr};

   // Grant decision: data wins unless fetch has waited MAX_D_STREAK data grants; flush blocks fetch.
   always_comb begin
      fetch_ok    = if_req & ~if_flush;
      streak_full = (streak_q == STREAK_MAX);
      if_gnt      = rst_n & fetch_ok & (~d_req | streak_full);
      d_gnt       = rst_n & d_req & ~if_gnt;
   end

   // Memory port mux: driven only in a grant cycle, all zero otherwise.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      if (if_gnt) begin
         mem_en   = 1'b1;
         mem_be   = 4'b1111;
         mem_addr = if_addr[MEM_AW+1:2];
      end else if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_be    = d_be;
         mem_addr  = d_addr[MEM_AW+1:2];
         mem_wdata = d_wdata;
      end
   end

   // Next streak count and response owner for the grant made this cycle.
   always_comb begin
      streak_d = streak_q;
      owner_d  = OWN_NONE;
      if (if_gnt || !if_req) begin
         streak_d = '0;
      end else if (d_gnt && !streak_full) begin
         streak_d = streak_q + 1'b1;
      end
      if (if_gnt) begin
         owner_d = OWN_FETCH;
      end else if (d_gnt) begin
         owner_d = d_we ? OWN_DWRITE : OWN_DREAD;
      end
   end

   // State registers; reset drops any outstanding response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= OWN_NONE;
         streak_q <= '0;
      end else begin
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   // Response path: one cycle after grant; a flush kills an in-flight fetch response.
   always_comb begin
      if_rvalid = (owner_q == OWN_FETCH) & ~if_flush;
      if_rdata  = if_rvalid ? mem_rdata : 32'h0;
      d_rvalid  = (owner_q == OWN_DREAD) | (owner_q == OWN_DWRITE);
      d_rdata   = (owner_q == OWN_DREAD) ? mem_rdata : 32'h0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(32), .MEM_AW(10), .MAX_D_STREAK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge and clear all requests.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      if_req = 0; if_flush = 0; d_req = 0; d_we = 0; d_be = 4'h0;
      if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF;
      if_addr = 32'h40; d_addr = 32'h44; d_wdata = 32'h1234_5678; if_flush = 0; mem_rdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #2;
      checks++; if ({if_gnt, d_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", {if_gnt, d_gnt}); end
      checks++; if ({mem_en, mem_we, mem_be} !== 6'b0) begin errors++; $display("FAIL reset_mem_ctl got=%b exp=0", {mem_en, mem_we, mem_be}); end
      checks++; if ({mem_addr, mem_wdata} !== 42'h0) begin errors++; $display("FAIL reset_mem_data got=%h exp=0", {mem_addr, mem_wdata}); end
      checks++; if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 66'h0) begin errors++; $display("FAIL reset_resp got=%h exp=0", {if_rvalid, d_rvalid, if_rdata, d_rdata}); end
      // Release with a data read pending: granted in the very first cycle.
      next_cycle();
      rst_n = 1; d_req = 1; d_addr = 32'h20;
      #1;
      checks++; if (d_gnt !== 1'b1 || mem_addr !== 10'd8) begin errors++; $display("FAIL reset_first_gnt got=%b/%0d exp=1/8", d_gnt, mem_addr); end
      next_cycle();
      mem_rdata = 32'hCAFE_0001;
      #1;
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL reset_first_resp got=%b/%h exp=1/cafe0001", d_rvalid, d_rdata); end
   endtask

   task automatic test_single_fetch();
      next_cycle();
      if_req = 1; if_addr = 32'h8;
      #1;
      checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got=%b%b exp=10", if_gnt, d_gnt); end
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 10'd2) begin
         errors++; $display("FAIL fetch_mem got en=%b we=%b be=%h addr=%0d exp 1/0/f/2", mem_en, mem_we, mem_be, mem_addr); end
      next_cycle();
      mem_rdata = 32'h0050_0093;
      #1;
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_resp got=%b/%h exp=1/00500093", if_rvalid, if_rdata); end
      checks++; if (d_rvalid !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL fetch_idle got=%b/%b exp=0/0", d_rvalid, mem_en); end
      next_cycle();
      mem_rdata = 32'h5555_AAAA;
      #1;
      checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL fetch_resp_once got=%b/%h exp=0/0", if_rvalid, if_rdata); end
   endtask

   task automatic test_store();
      next_cycle();
      d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'hC; d_wdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 10'd3 || mem_wdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL store_mem got gnt=%b en=%b we=%b be=%b addr=%0d wd=%h exp 1/1/1/0011/3/deadbeef", d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata); end
      next_cycle();
      mem_rdata = 32'h7777_7777;
      #1;
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL store_ack got=%b/%h/%b exp=1/0/0", d_rvalid, d_rdata, if_rvalid); end
   endtask

   // Both requesters held high: D,D,D,D,F repeated, each response one cycle after its grant.
   task automatic test_back_to_back();
      logic prev_f;
      prev_f = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         next_cycle();
         mem_rdata = 32'h1000 + i;
         if (i < 10) begin
            if_req = 1; if_addr = 32'h100; d_req = 1; d_addr = 32'h200;
         end
         #1;
         if (i < 10) begin
            checks++; if ({if_gnt, d_gnt} !== (((i % 5) == 4) ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL contention_gnt[%0d] got=%b%b exp=%s", i, if_gnt, d_gnt, ((i % 5) == 4) ? "10" : "01"); end
         end
         if (i > 0) begin
            checks++; if ({if_rvalid, d_rvalid} !== (prev_f ? 2'b10 : 2'b01) ||
                          (prev_f ? if_rdata : d_rdata) !== 32'h1000 + i) begin
               errors++; $display("FAIL contention_resp[%0d] got=%b%b if=%h d=%h exp_fetch=%b data=%h", i, if_rvalid, d_rvalid, if_rdata, d_rdata, prev_f, 32'h1000 + i); end
         end
         prev_f = ((i % 5) == 4);
      end
   endtask

   task automatic test_flush();
      next_cycle();
      if_req = 1; if_addr = 32'h10;
      #1;
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_n_gnt got=%b exp=1", if_gnt); end
      next_cycle();
      if_req = 1; if_addr = 32'h14; if_flush = 1; d_req = 1; d_addr = 32'h30; mem_rdata = 32'hBAD0_BAD0;
      #1;
      checks++; if (if_gnt !== 1'b0 || if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
         errors++; $display("FAIL flush_n1 got gnt=%b rv=%b rd=%h exp 0/0/0", if_gnt, if_rvalid, if_rdata); end
      checks++; if (d_gnt !== 1'b1 || mem_addr !== 10'd12) begin errors++; $display("FAIL flush_data_gnt got=%b/%0d exp=1/12", d_gnt, mem_addr); end
      next_cycle();
      if_req = 1; if_addr = 32'h14; mem_rdata = 32'h0000_D00D;
      #1;
      checks++; if (if_gnt !== 1'b1 || mem_addr !== 10'd5 || if_rvalid !== 1'b0) begin
         errors++; $display("FAIL flush_n2 got gnt=%b addr=%0d rv=%b exp 1/5/0", if_gnt, mem_addr, if_rvalid); end
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000_D00D) begin errors++; $display("FAIL flush_data_resp got=%b/%h exp=1/0000d00d", d_rvalid, d_rdata); end
      next_cycle();
      mem_rdata = 32'h0000_0013;
      #1;
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) begin errors++; $display("FAIL flush_refetch_resp got=%b/%h exp=1/13", if_rvalid, if_rdata); end
   endtask

   task automatic test_reset_midop();
      next_cycle();
      d_req = 1; d_addr = 32'h40;
      #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL midop_gnt got=%b exp=1", d_gnt); end
      rst_n = 0;
      #1;
      checks++; if ({d_gnt, mem_en, mem_addr} !== 12'h0) begin errors++; $display("FAIL midop_async got=%h exp=0", {d_gnt, mem_en, mem_addr}); end
      next_cycle();
      mem_rdata = 32'h1111_2222;
      #1;
      checks++; if ({d_rvalid, d_rdata, if_rvalid, if_rdata} !== 66'h0) begin errors++; $display("FAIL midop_resp got=%h exp=0", {d_rvalid, d_rdata, if_rvalid, if_rdata}); end
      next_cycle();
      rst_n = 1;
      next_cycle();
      mem_rdata = 32'h3333_4444;
      #1;
      checks++; if ({d_rvalid, d_rdata, if_rvalid, if_rdata} !== 66'h0) begin errors++; $display("FAIL midop_after_release got=%h exp=0", {d_rvalid, d_rdata, if_rvalid, if_rdata}); end
   endtask

   // d_req and if_req alternate: one grant per cycle, responses alternate without overlap.
   task automatic test_alternating();
      for (int i = 0; i <= 8; i++) begin
         next_cycle();
         mem_rdata = 32'hA000 + i;
         if (i < 8) begin
            if (i % 2 == 0) begin d_req = 1; d_addr = 32'(i * 4); end
            else begin if_req = 1; if_addr = 32'(i * 4); end
         end
         #1;
         if (i < 8) begin
            checks++; if ({if_gnt, d_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10) || mem_addr !== 10'(i)) begin
               errors++; $display("FAIL alt_gnt[%0d] got=%b%b addr=%0d exp_data=%0d addr=%0d", i, if_gnt, d_gnt, mem_addr, (i % 2 == 0), i); end
         end
         if (i > 0) begin
            checks++; if ({if_rvalid, d_rvalid} !== (((i - 1) % 2 == 0) ? 2'b01 : 2'b10) ||
                          (if_rdata | d_rdata) !== 32'hA000 + i) begin
               errors++; $display("FAIL alt_resp[%0d] got=%b%b rd=%h exp_data=%0d rd=%h", i, if_rvalid, d_rvalid, if_rdata | d_rdata, ((i - 1) % 2 == 0), 32'hA000 + i); end
         end
      end
      // Streak stayed at zero: with both requesting, four data grants precede the fetch.
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         if_req = 1; d_req = 1;
         #1;
         checks++; if ({if_gnt, d_gnt} !== ((i == 4) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL alt_streak[%0d] got=%b%b exp=%s", i, if_gnt, d_gnt, (i == 4) ? "10" : "01"); end
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store();
      test_back_to_back();
      test_flush();
      test_reset_midop();
      test_alternating();
      next_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of both requesters.
REQ-002 SHALL have parameter MEM_AW, default 10, word-address width of memory port.
REQ-003 SHALL have parameter MAX_D_STREAK, default 4, consecutive data grants allowed while fetch waits.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-005 SHALL have fetch ports: if_req in 1, if_addr in ADDR_W, if_flush in 1, if_gnt out 1, if_rvalid out 1, if_rdata out 32.
REQ-006 SHALL have data ports: d_req in 1, d_we in 1, d_be in 4, d_addr in ADDR_W, d_wdata in 32, d_gnt out 1, d_rvalid out 1, d_rdata out 32.
REQ-007 SHALL have memory ports: mem_en out 1, mem_we out 1, mem_be out 4, mem_addr out MEM_AW, mem_wdata out 32, mem_rdata in 32 (synchronous, data valid one cycle after mem_en).

Function
REQ-008 SHALL grant at most one requester per cycle; if_gnt and d_gnt never both high.
REQ-009 SHALL generate grants combinationally in the cycle the request is high; requester holds req/addr/data stable until granted.
REQ-010 SHALL drive mem_en=1 in the grant cycle only; mem_addr = granted addr[MEM_AW+1:2]; low two address bits ignored.
REQ-011 SHALL drive for a data grant: mem_we=d_we, mem_be=d_be, mem_wdata=d_wdata; for a fetch grant: mem_we=0, mem_be=4'b1111.
REQ-012 SHALL drive mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0 when no grant.
REQ-013 SHALL give priority to data when both request, except per REQ-015.
REQ-014 SHALL keep streak counter: +1 on each data grant while if_req high; cleared on fetch grant or any cycle if_req low; saturates at MAX_D_STREAK.
REQ-015 SHALL grant fetch when both request and streak == MAX_D_STREAK; counter clears that cycle.
REQ-016 SHALL register response owner (none/fetch/data-read/data-write) at grant; exactly one cycle later assert matching rvalid for one cycle.
REQ-017 SHALL return if_rdata/d_rdata = mem_rdata on read response; 0 whenever corresponding rvalid is low.
REQ-018 SHALL ack data write with d_rvalid=1, d_rdata=0 one cycle after grant.
REQ-019 SHALL, on if_flush high, suppress if_rvalid for any fetch granted in the previous cycle, and deny if_gnt in the flush cycle; data traffic unaffected.
REQ-020 SHALL support back-to-back grants every cycle (full throughput; response of grant N coincides with grant N+1).
REQ-021 SHALL handle a data grant after a fetch grant without loss: if_rvalid and d_rvalid in consecutive cycles.

Reset
REQ-022 SHALL on rst_n low immediately force all outputs to 0, streak counter to 0, response owner to none.
REQ-023 SHALL drop any outstanding response when reset asserts mid-operation; no rvalid after reset release until a new grant.
REQ-024 SHALL issue first grant in the first clk edge cycle with rst_n high and a request present.

Verification
REQ-025 Single fetch: if_req=1, if_addr=0x8, mem_rdata=0x00500093 -> if_gnt same cycle, mem_addr=2, if_rvalid next cycle, if_rdata=0x00500093.
REQ-026 Contention: if_req and d_req both held high, MAX_D_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F; if_rvalid/d_rvalid each one cycle after its grant.
REQ-027 Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0xC, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, mem_addr=3, mem_wdata=0xDEADBEEF; d_rvalid=1, d_rdata=0 next cycle.
REQ-028 Flush: fetch granted cycle N, if_flush=1 cycle N+1 -> if_rvalid=0 at N+1, if_gnt=0 at N+1 even with if_req=1; fetch granted again at N+2.
REQ-029 Reset mid-op: data read granted, rst_n low before next edge -> d_rvalid=0, all outputs 0, no response after release.
REQ-030 Alternating: d_req one cycle, if_req next, repeated 8 cycles -> every cycle one grant, responses never overlap, streak stays 0.
